// File: rtl/adder_rr_sched.sv
// Round-robin front end that shares one fixed-latency adder among NUM_REQ requesters,
// with credit-limited issue and an in-order first-word-fall-through response FIFO.
module adder_rr_sched #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REQ       = 4,
    parameter int ADDER_LATENCY = 1,
    parameter int RSP_DEPTH     = 4,
    localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]            req_cin,
    output logic                          add_valid_in,
    output logic [DATA_WIDTH-1:0]         add_a,
    output logic [DATA_WIDTH-1:0]         add_b,
    output logic                          add_cin,
    input  logic                          add_valid_out,
    input  logic [DATA_WIDTH-1:0]         add_sum,
    input  logic                          add_cout,
    input  logic                          add_ovf,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IDW-1:0]                rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_sum,
    output logic                          rsp_cout,
    output logic                          rsp_ovf,
    output logic                          busy,
    output logic                          err
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_badNumReq
        $fatal(1, "adder_rr_sched: NUM_REQ must be in 2..8");
    end
    if (ADDER_LATENCY < 1 || ADDER_LATENCY > 8) begin : g_badLatency
        $fatal(1, "adder_rr_sched: ADDER_LATENCY must be in 1..8");
    end
    if (RSP_DEPTH < ADDER_LATENCY || RSP_DEPTH > 16) begin : g_badDepth
        $fatal(1, "adder_rr_sched: RSP_DEPTH must be in ADDER_LATENCY..16");
    end

    logic [IDW-1:0]           r_ptr;
    logic [CW-1:0]            r_used;
    logic                     r_err;
    logic [ADDER_LATENCY-1:0] r_tagValid;
    logic [IDW-1:0]           r_tagId [ADDER_LATENCY];
    logic [CW-1:0]            r_count;
    logic [PW-1:0]            r_wrPtr;
    logic [PW-1:0]            r_rdPtr;
    logic [IDW-1:0]           r_memId   [RSP_DEPTH];
    logic [DATA_WIDTH-1:0]    r_memSum  [RSP_DEPTH];
    logic                     r_memCout [RSP_DEPTH];
    logic                     r_memOvf  [RSP_DEPTH];

    logic [IDW-1:0] w_grant;
    logic           w_anyReq;
    logic           w_canIssue;
    logic           w_issue;
    logic           w_tagValidOut;
    logic [IDW-1:0] w_tagIdOut;
    logic           w_full;
    logic           w_push;
    logic           w_pop;

    // Scan from the highest offset down so the lowest offset at or after r_ptr wins.
    always_comb begin
        int idx;
        idx      = 0;
        w_grant  = r_ptr;
        w_anyReq = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_grant  = IDW'(idx);
                w_anyReq = 1'b1;
            end
        end
    end

    assign w_canIssue   = rst_n && (r_used < CW'(RSP_DEPTH));
    assign w_issue      = w_canIssue && w_anyReq;
    assign req_ready    = w_issue ? (NUM_REQ'(1) << w_grant) : '0;
    assign add_valid_in = w_issue;
    assign add_a        = w_issue ? req_a[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign add_b        = w_issue ? req_b[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign add_cin      = w_issue ? req_cin[w_grant] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_used <= '0;
        end else begin
            if (w_issue) begin
                r_ptr <= (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + 1'b1;
            end
            if (w_issue && !w_pop) begin
                r_used <= r_used + 1'b1;
            end else if (!w_issue && w_pop) begin
                r_used <= r_used - 1'b1;
            end
        end
    end

    // Tags travel alongside the adder so each result can be matched to its requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tagValid <= '0;
            for (int i = 0; i < ADDER_LATENCY; i++) begin
                r_tagId[i] <= '0;
            end
        end else begin
            r_tagValid[0] <= w_issue;
            r_tagId[0]    <= w_grant;
            for (int i = 1; i < ADDER_LATENCY; i++) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagId[i]    <= r_tagId[i-1];
            end
        end
    end

    assign w_tagValidOut = r_tagValid[ADDER_LATENCY-1];
    assign w_tagIdOut    = r_tagId[ADDER_LATENCY-1];
    assign w_full        = (r_count == CW'(RSP_DEPTH));
    assign w_push        = add_valid_out && w_tagValidOut && !w_full;
    assign rsp_valid     = (r_count != '0);
    assign w_pop         = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (int'(r_wrPtr) == RSP_DEPTH - 1) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= (int'(r_rdPtr) == RSP_DEPTH - 1) ? '0 : r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if ((add_valid_out != w_tagValidOut) || (add_valid_out && w_tagValidOut && w_full)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memId[r_wrPtr]   <= w_tagIdOut;
            r_memSum[r_wrPtr]  <= add_sum;
            r_memCout[r_wrPtr] <= add_cout;
            r_memOvf[r_wrPtr]  <= add_ovf;
        end
    end

    assign rsp_id   = r_memId[r_rdPtr];
    assign rsp_sum  = r_memSum[r_rdPtr];
    assign rsp_cout = r_memCout[r_rdPtr];
    assign rsp_ovf  = r_memOvf[r_rdPtr];
    assign busy     = (r_used != '0);
    assign err      = r_err;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Bench for adder_rr_sched: emulates the shared adder and predicts grants and responses
// with a queue-based scoreboard driven by the round-robin and credit rules.
module tb_adder_rr_sched;

    localparam int DW    = 32;
    localparam int NR    = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0]    req_cin;
    logic             add_valid_in;
    logic [DW-1:0]    add_a;
    logic [DW-1:0]    add_b;
    logic             add_cin;
    logic             add_valid_out;
    logic [DW-1:0]    add_sum;
    logic             add_cout;
    logic             add_ovf;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [DW-1:0]    rsp_sum;
    logic             rsp_cout;
    logic             rsp_ovf;
    logic             busy;
    logic             err;
    logic             injectPulse;

    int nChecks = 0;
    int nErrors = 0;

    adder_rr_sched #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .ADDER_LATENCY(LAT), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_valid_in(add_valid_in), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_valid_out(add_valid_out), .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Shared adder emulation: fixed LAT-cycle pipeline, plus a pulse hook for protocol errors.
    logic [DW:0]    adderFull;
    logic [LAT-1:0] pipeV;
    logic [DW-1:0]  pipeSum  [LAT];
    logic           pipeCout [LAT];
    logic           pipeOvf  [LAT];

    assign adderFull = {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipeV <= '0;
        end else begin
            pipeV[0]    <= add_valid_in;
            pipeSum[0]  <= adderFull[DW-1:0];
            pipeCout[0] <= adderFull[DW];
            pipeOvf[0]  <= (add_a[DW-1] == add_b[DW-1]) && (adderFull[DW-1] != add_a[DW-1]);
            for (int i = 1; i < LAT; i++) begin
                pipeV[i]    <= pipeV[i-1];
                pipeSum[i]  <= pipeSum[i-1];
                pipeCout[i] <= pipeCout[i-1];
                pipeOvf[i]  <= pipeOvf[i-1];
            end
        end
    end

    assign add_valid_out = pipeV[LAT-1] | injectPulse;
    assign add_sum       = pipeSum[LAT-1];
    assign add_cout      = pipeCout[LAT-1];
    assign add_ovf       = pipeOvf[LAT-1];

    // Scoreboard: each issued op becomes visible LAT+1 cycles later and leaves in issue order.
    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  sum;
        logic           cout;
        logic           ovf;
        int             due;
    } rsp_t;

    rsp_t expQ[$];
    int   mPtr  = 0;
    int   mUsed = 0;
    int   cyc   = 0;

    function automatic int modelGrant();
        if (!rst_n || mUsed >= DEPTH) return -1;
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(mPtr + k) % NR]) return (mPtr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic modelRspValid();
        return (expQ.size() > 0) && (expQ[0].due <= cyc);
    endfunction

    always @(posedge clk or negedge rst_n) begin : p_model
        int          g;
        logic        popNow;
        rsp_t        e;
        logic [DW:0] s;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        if (!rst_n) begin
            expQ.delete();
            mPtr  <= 0;
            mUsed <= 0;
            cyc   <= 0;
        end else begin
            g      = modelGrant();
            popNow = modelRspValid() && rsp_ready;
            if (popNow) void'(expQ.pop_front());
            if (g >= 0) begin
                a      = req_a[g*DW +: DW];
                b      = req_b[g*DW +: DW];
                s      = {1'b0, a} + {1'b0, b} + (DW+1)'(req_cin[g]);
                e.id   = IDW'(g);
                e.sum  = s[DW-1:0];
                e.cout = s[DW];
                e.ovf  = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
                e.due  = cyc + LAT + 1;
                expQ.push_back(e);
                mPtr <= (g + 1) % NR;
            end
            mUsed <= mUsed + ((g >= 0) ? 1 : 0) - (popNow ? 1 : 0);
            cyc   <= cyc + 1;
        end
    end

    task automatic randomOperands();
        for (int k = 0; k < NR; k++) begin
            req_a[k*DW +: DW] = $urandom();
            req_b[k*DW +: DW] = $urandom();
        end
        req_cin = NR'($urandom_range(0, 15));
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        req_valid   = '0;
        rsp_ready   = 1'b0;
        injectPulse = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        injectPulse = 1'b0;
        req_valid   = '1;
        rsp_ready   = 1'b1;
        randomOperands();
        @(negedge clk);
        nChecks += 8;
        if (req_ready !== '0) begin nErrors++; $display("[TB] FAIL resetReqReady: got %b expected 0", req_ready); end
        if (add_valid_in !== 1'b0) begin nErrors++; $display("[TB] FAIL resetAddValid: got %b expected 0", add_valid_in); end
        if (add_a !== '0) begin nErrors++; $display("[TB] FAIL resetAddA: got %h expected 0", add_a); end
        if (add_b !== '0) begin nErrors++; $display("[TB] FAIL resetAddB: got %h expected 0", add_b); end
        if (add_cin !== 1'b0) begin nErrors++; $display("[TB] FAIL resetAddCin: got %b expected 0", add_cin); end
        if (rsp_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL resetRspValid: got %b expected 0", rsp_valid); end
        if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL resetBusy: got %b expected 0", busy); end
        if (err !== 1'b0) begin nErrors++; $display("[TB] FAIL resetErr: got %b expected 0", err); end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_a          = '0;
        req_b          = '0;
        req_a[DW-1:0]  = 32'd5;
        req_b[DW-1:0]  = 32'd7;
        req_cin        = 4'b0001;
        req_valid      = 4'b0001;
        @(negedge clk);
        nChecks += 4;
        if (req_ready !== 4'b0001) begin nErrors++; $display("[TB] FAIL singleReady: got %b expected 0001", req_ready); end
        if (add_valid_in !== 1'b1) begin nErrors++; $display("[TB] FAIL singleAddValid: got %b expected 1", add_valid_in); end
        if (add_a !== 32'd5) begin nErrors++; $display("[TB] FAIL singleAddA: got %0d expected 5", add_a); end
        if (add_cin !== 1'b1) begin nErrors++; $display("[TB] FAIL singleAddCin: got %b expected 1", add_cin); end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        nChecks++;
        if (rsp_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL singleEarlyRsp: got %b expected 0", rsp_valid); end
        @(negedge clk);
        nChecks += 3;
        if (rsp_valid !== 1'b1) begin nErrors++; $display("[TB] FAIL singleRspValid: got %b expected 1", rsp_valid); end
        if (rsp_id !== 2'd0) begin nErrors++; $display("[TB] FAIL singleRspId: got %0d expected 0", rsp_id); end
        if (rsp_sum !== 32'd13) begin nErrors++; $display("[TB] FAIL singleRspSum: got %0d expected 13", rsp_sum); end
        @(negedge clk);
        nChecks += 2;
        if (rsp_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL singleRspDrained: got %b expected 0", rsp_valid); end
        if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL singleBusyDrained: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0]  expReady;
        logic [IDW-1:0] gotIds[$];
        doReset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            req_valid = (i < 6) ? '1 : '0;
            randomOperands();
            @(negedge clk);
            if (i < 6) begin
                expReady = NR'(1) << (i % NR);
                nChecks++;
                if (req_ready !== expReady) begin nErrors++; $display("[TB] FAIL rrGrant%0d: got %b expected %b", i, req_ready, expReady); end
            end
            if (rsp_valid === 1'b1) begin
                gotIds.push_back(rsp_id);
                if (expQ.size() > 0) begin
                    nChecks++;
                    if (rsp_sum !== expQ[0].sum) begin nErrors++; $display("[TB] FAIL rrSum: got %h expected %h", rsp_sum, expQ[0].sum); end
                end
            end
        end
        nChecks++;
        if (gotIds.size() != 6) begin nErrors++; $display("[TB] FAIL rrRspCount: got %0d expected 6", gotIds.size()); end
        for (int j = 0; j < gotIds.size(); j++) begin
            nChecks++;
            if (gotIds[j] !== IDW'(j % NR)) begin nErrors++; $display("[TB] FAIL rrRspOrder%0d: got %0d expected %0d", j, gotIds[j], j % NR); end
        end
    endtask

    task automatic test_credit();
        int issues;
        issues = 0;
        doReset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            req_valid = '1;
            randomOperands();
            @(negedge clk);
            issues += $countones(req_ready);
        end
        nChecks += 4;
        if (issues != DEPTH) begin nErrors++; $display("[TB] FAIL creditIssues: got %0d expected %0d", issues, DEPTH); end
        if (req_ready !== '0) begin nErrors++; $display("[TB] FAIL creditStall: got %b expected 0000", req_ready); end
        if (busy !== 1'b1) begin nErrors++; $display("[TB] FAIL creditBusy: got %b expected 1", busy); end
        if (rsp_valid !== 1'b1) begin nErrors++; $display("[TB] FAIL creditRspValid: got %b expected 1", rsp_valid); end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        nChecks++;
        if (req_ready !== '0) begin nErrors++; $display("[TB] FAIL creditNoBypass: got %b expected 0000", req_ready); end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        nChecks++;
        if (req_ready !== 4'b0001) begin nErrors++; $display("[TB] FAIL creditOneIssue: got %b expected 0001", req_ready); end
        @(negedge clk);
        nChecks++;
        if (req_ready !== '0) begin nErrors++; $display("[TB] FAIL creditRestall: got %b expected 0000", req_ready); end
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        nChecks++;
        if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL creditDrained: got %b expected 0", busy); end
    endtask

    task automatic test_alternate();
        logic [NR-1:0] expReady;
        doReset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            req_valid = 4'b0101;
            randomOperands();
            @(negedge clk);
            expReady = (i % 2 == 1) ? 4'b0100 : 4'b0001;
            nChecks++;
            if (req_ready !== expReady) begin nErrors++; $display("[TB] FAIL altGrant%0d: got %b expected %b", i, req_ready, expReady); end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_random();
        int            g;
        logic [NR-1:0] expReady;
        logic [DW-1:0] expA;
        logic [DW-1:0] expB;
        logic          expCin;
        logic          expRsp;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            req_valid = NR'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            randomOperands();
            @(negedge clk);
            g        = modelGrant();
            expReady = (g >= 0) ? (NR'(1) << g) : '0;
            expA     = (g >= 0) ? req_a[g*DW +: DW] : '0;
            expB     = (g >= 0) ? req_b[g*DW +: DW] : '0;
            expCin   = (g >= 0) ? req_cin[g] : 1'b0;
            expRsp   = modelRspValid();
            nChecks += 8;
            if (req_ready !== expReady) begin nErrors++; $display("[TB] FAIL rndReady: got %b expected %b", req_ready, expReady); end
            if (add_valid_in !== (g >= 0)) begin nErrors++; $display("[TB] FAIL rndAddValid: got %b expected %b", add_valid_in, g >= 0); end
            if (add_a !== expA) begin nErrors++; $display("[TB] FAIL rndAddA: got %h expected %h", add_a, expA); end
            if (add_b !== expB) begin nErrors++; $display("[TB] FAIL rndAddB: got %h expected %h", add_b, expB); end
            if (add_cin !== expCin) begin nErrors++; $display("[TB] FAIL rndAddCin: got %b expected %b", add_cin, expCin); end
            if (rsp_valid !== expRsp) begin nErrors++; $display("[TB] FAIL rndRspValid: got %b expected %b", rsp_valid, expRsp); end
            if (busy !== (mUsed != 0)) begin nErrors++; $display("[TB] FAIL rndBusy: got %b expected %b", busy, mUsed != 0); end
            if (err !== 1'b0) begin nErrors++; $display("[TB] FAIL rndErr: got %b expected 0", err); end
            if (expRsp) begin
                nChecks += 4;
                if (rsp_id !== expQ[0].id) begin nErrors++; $display("[TB] FAIL rndRspId: got %0d expected %0d", rsp_id, expQ[0].id); end
                if (rsp_sum !== expQ[0].sum) begin nErrors++; $display("[TB] FAIL rndRspSum: got %h expected %h", rsp_sum, expQ[0].sum); end
                if (rsp_cout !== expQ[0].cout) begin nErrors++; $display("[TB] FAIL rndRspCout: got %b expected %b", rsp_cout, expQ[0].cout); end
                if (rsp_ovf !== expQ[0].ovf) begin nErrors++; $display("[TB] FAIL rndRspOvf: got %b expected %b", rsp_ovf, expQ[0].ovf); end
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) @(negedge clk);
        nChecks += 2;
        if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL rndDrainBusy: got %b expected 0", busy); end
        if (rsp_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL rndDrainRsp: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_spurious_err();
        @(posedge clk);
        #1;
        req_valid   = '0;
        injectPulse = 1'b1;
        @(posedge clk);
        #1;
        injectPulse = 1'b0;
        @(negedge clk);
        nChecks += 2;
        if (err !== 1'b1) begin nErrors++; $display("[TB] FAIL spurErrSet: got %b expected 1", err); end
        if (rsp_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL spurNoPush: got %b expected 0", rsp_valid); end
        repeat (3) @(negedge clk);
        nChecks += 3;
        if (err !== 1'b1) begin nErrors++; $display("[TB] FAIL spurErrSticky: got %b expected 1", err); end
        if (rsp_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL spurRspLater: got %b expected 0", rsp_valid); end
        if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL spurBusy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int issues;
        issues    = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            req_valid = '1;
            randomOperands();
            @(negedge clk);
            issues += $countones(req_ready);
        end
        nChecks++;
        if (issues != 4) begin nErrors++; $display("[TB] FAIL midIssues: got %0d expected 4", issues); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        nChecks += 3;
        if (rsp_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL midRspValid: got %b expected 0", rsp_valid); end
        if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL midBusy: got %b expected 0", busy); end
        if (req_ready !== '0) begin nErrors++; $display("[TB] FAIL midReqReady: got %b expected 0000", req_ready); end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nChecks += 3;
            if (rsp_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL midStale%0d: got %b expected 0", i, rsp_valid); end
            if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL midIdle%0d: got %b expected 0", i, busy); end
            if (err !== 1'b0) begin nErrors++; $display("[TB] FAIL midErr%0d: got %b expected 0", i, err); end
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0010;
        randomOperands();
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nChecks++;
            if (rsp_valid !== modelRspValid()) begin nErrors++; $display("[TB] FAIL midNewRsp%0d: got %b expected %b", i, rsp_valid, modelRspValid()); end
            if (modelRspValid()) begin
                nChecks += 2;
                if (rsp_id !== 2'd1) begin nErrors++; $display("[TB] FAIL midNewId: got %0d expected 1", rsp_id); end
                if (rsp_sum !== expQ[0].sum) begin nErrors++; $display("[TB] FAIL midNewSum: got %h expected %h", rsp_sum, expQ[0].sum); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_credit();
        test_alternate();
        test_random();
        test_spurious_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
